rrat_retire: RTL and testbench
==============================

# rrat_retire

Retirement register alias table (RRAT) at the commit end of the rename/free-list protocol. It receives in-order commits from the ROB, records the committed architectural-to-physical mapping, and returns each superseded physical register to the rename stage's free list through the `rrat_free`/`rrat_free_reg` pair. Its map feeds FRAT recovery on FLUSH. With the rebuild feature compiled in, it also re-seeds the free list after a flush by scanning all physical registers.

## Interface
Parameters:
- `NUM_PHYS`, 64: number of physical registers. The index width is 6 bits and is fixed for this value.
- `NUM_ARCH`, 32: number of architectural registers. Reset maps arch *i* to phys *i*.

Ports:
- `CLK`, input, 1: the single clock. All state updates on the falling edge, matching the rename stage.
- `RESET`, input, 1: asynchronous, active-low reset.
- `FLUSH`, input, 1: pipeline flush from the ROB, sampled on the falling edge.
- `commit_valid`, input, 1: one instruction retires this cycle.
- `commit_regwr`, input, 1: the retiring instruction wrote a register (regwrite or load).
- `commit_arch_reg`, input, 5: architectural destination.
- `commit_phys_reg`, input, 6: physical register allocated at rename.
- `rrat_free`, output, 1: one-cycle pulse; return `rrat_free_reg` to the free list.
- `rrat_free_reg`, output, 6: physical register being freed.
- `rrat_map`, output, 6 × [31:0]: committed mapping, same shape as `frat_my_map`.
- `commit_halt`, output, 1: the ROB must not commit while this is high.
- `retired_num`, output, integer: count of accepted commits.

## Operation
- **State:**
  - `map[31:0]` (6 bits each).
  - `inuse[63:0]`: physical registers referenced by the committed map.
  - FSM {IDLE, SCAN}.
  - 6-bit `scan_idx`.
- **Reset:**
  - `map[i]=i`.
  - `inuse[31:0]=1`, `inuse[63:32]=0`.
  - FSM=IDLE, `scan_idx=0`.
  - `rrat_free=0`, `rrat_free_reg=0`, `commit_halt=0`, `retired_num=0`.
- **Commit accepted:** `commit_valid & !commit_halt`. It increments `retired_num`. If `commit_regwr` is low, nothing else changes.
- **Commit with `commit_regwr`, arch ≠ 0:**
  - `old = map[arch]`.
  - `map[arch] <= commit_phys_reg`.
  - `inuse[old] <= 0`, `inuse[commit_phys_reg] <= 1`.
  - Next edge drives `rrat_free=1`, `rrat_free_reg=old`.
- **Commit with `commit_regwr`, arch = 0:**
  - The map is unchanged; $zero stays on phys 0.
  - `commit_phys_reg` is freed immediately, so no register leaks.
- **Idle cycles:** when there is no accepted writing commit and the FSM is not emitting, `rrat_free=0`. `rrat_free_reg` holds its last value.
- **`commit_valid` while `commit_halt=1`:** ignored completely. No count, no map change.
- **Commit that frees a register equal to `commit_phys_reg`:** cannot occur legally. If it does, the `inuse` set wins.
- **FSM with rebuild enabled:**
  - FLUSH in IDLE: go to SCAN with `scan_idx=0` and `commit_halt=1`.
  - In SCAN, each cycle: `rrat_free = !inuse[scan_idx]`, `rrat_free_reg = scan_idx`, then `scan_idx++`.
  - After index 63 is emitted: IDLE, `commit_halt=0`, `scan_idx` wraps to 0.
- **Simultaneous FLUSH and accepted commit:** the commit is older than the flush and is applied first. The resulting free pulse is suppressed, because the scan re-emits that register. The scan then starts on the next cycle and sees the updated `inuse`.
- **FLUSH during SCAN:** restart at `scan_idx=0`. Partial emissions are discarded by the free list's own flush.

## Timing
- **Commit to map:** commit sampled at falling edge *t*. `rrat_map` reflects it after *t*. The FRAT sees it on the next falling edge.
- **Commit to free:** `rrat_free` is registered and high for exactly the cycle after edge *t*.
- **Throughput:** back-to-back commits give back-to-back free pulses.
- **Scan length:** exactly 64 cycles of SCAN.
- **Halt timing:** `commit_halt` rises on the edge that samples FLUSH and falls on the edge that emits index 63.
- **Reset mid-scan:** immediate return to reset values with no further pulses.

## Configuration
- `RRAT_FLUSH_REBUILD_EN`
  - **Defined:** the SCAN FSM exists as described.
  - **Undefined:** no FSM, and `commit_halt` is tied to 0. FLUSH has no effect on this block; the free list relies on its INIT contents. The commit/free path is unchanged, including the FLUSH+commit case, where the pulse is not suppressed.

## Test plan
- **Reset:** assert and release RESET → `rrat_map[5]=5`, `rrat_free=0`, `commit_halt=0`, `retired_num=0`.
- **Single commit:** commit arch 5 to phys 40 → next cycle `rrat_free=1` with `rrat_free_reg=5`, `rrat_map[5]=40`, `retired_num=1`.
- **Repeated arch:** commit arch 5 to phys 41, then arch 5 to phys 42 on consecutive cycles → free pulses of 40 then 41 on consecutive cycles, final `rrat_map[5]=42`.
- **Arch 0:** commit arch 0 to phys 33 → `rrat_free_reg=33`, `rrat_map[0]=0`.
- **Rebuild scan (REBUILD_EN, map identity except 5→42):**
  - FLUSH → 64 SCAN cycles.
  - Pulses for indices 5 and 32..63 except 42, i.e. 32 pulses in ascending order.
  - `commit_halt=1` throughout; a `commit_valid` driven during the scan is ignored.
- **Flush corner cases (REBUILD_EN):**
  - FLUSH at `scan_idx=20` → restart at 0 and 64 further cycles.
  - FLUSH together with commit arch 7 to phys 50 → no direct pulse. The scan skips 50 and emits 7.

Source files
------------

// File: rtl/rrat_retire.sv
// rrat_retire: retirement register alias table.
//
// Records the committed arch->phys mapping from the in-order ROB commit
// stream and hands each superseded physical register back to the free list.
// All state changes on the falling edge of CLK, in step with the rename stage.
//
// Optional feature macro: RRAT_FLUSH_REBUILD_EN
//   defined   - a FLUSH starts a 64-cycle scan that re-emits every physical
//               register not referenced by the committed map; commits are
//               held off (commit_halt) for the duration of the scan.
//   undefined - no scan FSM, commit_halt tied low, FLUSH is ignored.
//
// Ports:
//   CLK              clock (falling-edge active)
//   RESET            asynchronous active-low reset
//   FLUSH            pipeline flush from the ROB
//   commit_valid     one instruction retires this cycle
//   commit_regwr     the retiring instruction wrote a register
//   commit_arch_reg  architectural destination
//   commit_phys_reg  physical register allocated at rename
//   rrat_free        one-cycle pulse: return rrat_free_reg to the free list
//   rrat_free_reg    physical register being freed
//   rrat_map         committed mapping, one entry per architectural register
//   commit_halt      ROB must not commit while high
//   retired_num      count of accepted commits
//
// FSM (rebuild build only):
//   state | meaning
//   IDLE  | normal commit/free operation
//   SCAN  | emitting free pulses for unused phys regs, commits halted

module rrat_retire #(
    parameter int NUM_PHYS = 64,
    parameter int NUM_ARCH = 32
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       FLUSH,
    input  logic       commit_valid,
    input  logic       commit_regwr,
    input  logic [4:0] commit_arch_reg,
    input  logic [5:0] commit_phys_reg,
    output logic       rrat_free,
    output logic [5:0] rrat_free_reg,
    output logic [5:0] rrat_map [NUM_ARCH-1:0],
    output logic       commit_halt,
    output integer     retired_num
);

    logic [NUM_PHYS-1:0] inuse;
    logic                accept;
    logic                wr_map;
    logic                wr_zero;
    logic [5:0]          old_phys;
    logic                commit_free;
    logic [5:0]          commit_free_reg;
    logic                next_free;
    logic [5:0]          next_free_reg;

    assign accept   = commit_valid & ~commit_halt;
    assign wr_map   = accept & commit_regwr & (commit_arch_reg != 5'd0);
    // $zero never remaps, so its newly allocated register goes straight back.
    assign wr_zero  = accept & commit_regwr & (commit_arch_reg == 5'd0);
    assign old_phys = rrat_map[commit_arch_reg];

    always_comb begin
        commit_free     = wr_map | wr_zero;
        commit_free_reg = wr_map ? old_phys : commit_phys_reg;
    end

`ifdef RRAT_FLUSH_REBUILD_EN
    typedef enum logic {IDLE, SCAN} state_t;

    state_t     state;
    state_t     next_state;
    logic [5:0] scan_idx;
    logic [5:0] next_scan_idx;

    always_ff @(negedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= IDLE;
            scan_idx <= '0;
        end else begin
            state    <= next_state;
            scan_idx <= next_scan_idx;
        end
    end

    // A commit sampled with FLUSH is still applied to map/inuse, but its
    // pulse is dropped: the scan that follows re-emits that register.
    always_comb begin
        next_state    = state;
        next_scan_idx = scan_idx;
        next_free     = 1'b0;
        next_free_reg = rrat_free_reg;
        if (FLUSH) begin
            next_state    = SCAN;
            next_scan_idx = '0;
        end else if (state == SCAN) begin
            next_free     = ~inuse[scan_idx];
            next_free_reg = scan_idx;
            next_scan_idx = scan_idx + 6'd1;
            if (scan_idx == 6'd63) begin
                next_state = IDLE;
            end
        end else if (commit_free) begin
            next_free     = 1'b1;
            next_free_reg = commit_free_reg;
        end
    end

    assign commit_halt = (state == SCAN);
`else
    logic unused_flush;
    logic unused_inuse;

    assign unused_flush = FLUSH;
    assign unused_inuse = ^inuse;
    assign commit_halt  = 1'b0;

    always_comb begin
        next_free     = commit_free;
        next_free_reg = commit_free ? commit_free_reg : rrat_free_reg;
    end
`endif

    always_ff @(negedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NUM_ARCH; i++) begin
                rrat_map[i] <= 6'(i);
            end
            inuse         <= {{(NUM_PHYS-NUM_ARCH){1'b0}}, {NUM_ARCH{1'b1}}};
            rrat_free     <= 1'b0;
            rrat_free_reg <= '0;
            retired_num   <= 0;
        end else begin
            rrat_free     <= next_free;
            rrat_free_reg <= next_free_reg;
            if (accept) begin
                retired_num <= retired_num + 1;
            end
            if (wr_map) begin
                rrat_map[commit_arch_reg] <= commit_phys_reg;
                // Set is written last so it wins if old == new.
                inuse[old_phys]           <= 1'b0;
                inuse[commit_phys_reg]    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rrat_retire.sv
// Directed self-checking bench for rrat_retire. Inputs change half a cycle
// away from the active (falling) clock edge; outputs are sampled just after
// the rising edge. The flush/scan section adapts to RRAT_FLUSH_REBUILD_EN.

module tb_rrat_retire;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       FLUSH = 1'b0;
    logic       commit_valid = 1'b0;
    logic       commit_regwr = 1'b0;
    logic [4:0] commit_arch_reg = '0;
    logic [5:0] commit_phys_reg = '0;
    logic       rrat_free;
    logic [5:0] rrat_free_reg;
    logic [5:0] rrat_map [31:0];
    logic       commit_halt;
    integer     retired_num;

    int total = 0;
    int bad = 0;
    logic [63:0] exp_used;

    rrat_retire dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .FLUSH           (FLUSH),
        .commit_valid    (commit_valid),
        .commit_regwr    (commit_regwr),
        .commit_arch_reg (commit_arch_reg),
        .commit_phys_reg (commit_phys_reg),
        .rrat_free       (rrat_free),
        .rrat_free_reg   (rrat_free_reg),
        .rrat_map        (rrat_map),
        .commit_halt     (commit_halt),
        .retired_num     (retired_num)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic commit(input logic [4:0] arch, input logic [5:0] phys, input logic wr);
        commit_valid    = 1'b1;
        commit_regwr    = wr;
        commit_arch_reg = arch;
        commit_phys_reg = phys;
    endtask

    task automatic idle();
        commit_valid = 1'b0;
        commit_regwr = 1'b0;
    endtask

`ifdef RRAT_FLUSH_REBUILD_EN
    // Runs 64 scan cycles (FLUSH already sampled) and checks every emission
    // against the bench's expected in-use set.
    task automatic scan_check(input string tag, input int drop_commit_at);
        int pulses = 0;
        for (int k = 0; k < 64; k++) begin
            if (k == drop_commit_at) idle();
            tick();
            chk({tag, "_free"}, rrat_free, !exp_used[k]);
            chk({tag, "_reg"}, rrat_free_reg, k);
            chk({tag, "_halt"}, commit_halt, (k == 63) ? 0 : 1);
            if (rrat_free) pulses++;
        end
        chk({tag, "_pulses"}, pulses, 64 - $countones(exp_used));
    endtask
`endif

    initial begin
        // reset
        repeat (3) tick();
        chk("rst_free_in_reset", rrat_free, 0);
        RESET = 1'b1;
        tick();
        chk("rst_map5", rrat_map[5], 5);
        chk("rst_map31", rrat_map[31], 31);
        chk("rst_free", rrat_free, 0);
        chk("rst_free_reg", rrat_free_reg, 0);
        chk("rst_halt", commit_halt, 0);
        chk("rst_retired", retired_num, 0);

        // single commit
        commit(5'd5, 6'd40, 1'b1);
        tick();
        chk("c1_free", rrat_free, 1);
        chk("c1_reg", rrat_free_reg, 5);
        chk("c1_map5", rrat_map[5], 40);
        chk("c1_retired", retired_num, 1);
        idle();
        tick();
        chk("c1_idle_free", rrat_free, 0);
        chk("c1_idle_reg_hold", rrat_free_reg, 5);

        // repeated arch, back-to-back
        commit(5'd5, 6'd41, 1'b1);
        tick();
        chk("rep1_free", rrat_free, 1);
        chk("rep1_reg", rrat_free_reg, 40);
        commit(5'd5, 6'd42, 1'b1);
        tick();
        chk("rep2_free", rrat_free, 1);
        chk("rep2_reg", rrat_free_reg, 41);
        idle();
        tick();
        chk("rep_idle_free", rrat_free, 0);
        chk("rep_map5", rrat_map[5], 42);
        chk("rep_retired", retired_num, 3);

        // commit without register write: counted, nothing else
        commit(5'd6, 6'd20, 1'b0);
        tick();
        chk("nowr_free", rrat_free, 0);
        chk("nowr_map6", rrat_map[6], 6);
        chk("nowr_retired", retired_num, 4);

        // arch 0
        commit(5'd0, 6'd33, 1'b1);
        tick();
        chk("z_free", rrat_free, 1);
        chk("z_reg", rrat_free_reg, 33);
        chk("z_map0", rrat_map[0], 0);
        chk("z_retired", retired_num, 5);
        idle();
        tick();
        chk("z_idle_free", rrat_free, 0);

        exp_used = {32'h0, 32'hFFFF_FFFF};
        exp_used[5]  = 1'b0;
        exp_used[42] = 1'b1;

`ifdef RRAT_FLUSH_REBUILD_EN
        // full rebuild scan, commit attempted throughout is ignored
        FLUSH = 1'b1;
        tick();
        chk("fl_free", rrat_free, 0);
        chk("fl_halt", commit_halt, 1);
        FLUSH = 1'b0;
        commit(5'd9, 6'd60, 1'b1);
        scan_check("scan1", 60);
        chk("scan1_retired", retired_num, 5);
        chk("scan1_map9", rrat_map[9], 9);
        tick();
        chk("scan1_after_free", rrat_free, 0);

        // flush at scan_idx=20 restarts from 0
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        repeat (20) tick();
        chk("mid_reg19", rrat_free_reg, 19);
        FLUSH = 1'b1;
        tick();
        chk("restart_free", rrat_free, 0);
        chk("restart_halt", commit_halt, 1);
        FLUSH = 1'b0;
        scan_check("scan2", -1);

        // flush with simultaneous commit arch 7 -> 50
        FLUSH = 1'b1;
        commit(5'd7, 6'd50, 1'b1);
        tick();
        FLUSH = 1'b0;
        idle();
        chk("flc_free", rrat_free, 0);
        chk("flc_halt", commit_halt, 1);
        chk("flc_map7", rrat_map[7], 50);
        chk("flc_retired", retired_num, 6);
        exp_used[7]  = 1'b0;
        exp_used[50] = 1'b1;
        scan_check("scan3", -1);
`else
        // FLUSH has no effect, and does not suppress a concurrent pulse
        FLUSH = 1'b1;
        tick();
        chk("fl_halt", commit_halt, 0);
        chk("fl_free", rrat_free, 0);
        commit(5'd7, 6'd50, 1'b1);
        tick();
        FLUSH = 1'b0;
        idle();
        chk("flc_free", rrat_free, 1);
        chk("flc_reg", rrat_free_reg, 7);
        chk("flc_halt", commit_halt, 0);
        chk("flc_map7", rrat_map[7], 50);
        chk("flc_retired", retired_num, 6);
        tick();
        chk("flc_idle_free", rrat_free, 0);
        exp_used[7]  = 1'b0;
        exp_used[50] = 1'b1;
`endif

        // back-to-back commits to different arch regs
        commit(5'd10, 6'd44, 1'b1);
        tick();
        chk("bb1_free", rrat_free, 1);
        chk("bb1_reg", rrat_free_reg, 10);
        commit(5'd11, 6'd45, 1'b1);
        tick();
        chk("bb2_free", rrat_free, 1);
        chk("bb2_reg", rrat_free_reg, 11);
        idle();
        tick();
        chk("bb_idle_free", rrat_free, 0);
        chk("bb_map10", rrat_map[10], 44);
        chk("bb_map11", rrat_map[11], 45);
        chk("bb_retired", retired_num, 8);
        exp_used[10] = 1'b0;
        exp_used[11] = 1'b0;
        exp_used[44] = 1'b1;
        exp_used[45] = 1'b1;

        // asynchronous reset while a pulse is active
`ifdef RRAT_FLUSH_REBUILD_EN
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        repeat (33) tick();
        chk("pre_rst_free", rrat_free, !exp_used[32]);
        chk("pre_rst_reg", rrat_free_reg, 32);
        chk("pre_rst_halt", commit_halt, 1);
`else
        commit(5'd12, 6'd46, 1'b1);
        tick();
        idle();
        chk("pre_rst_free", rrat_free, 1);
        chk("pre_rst_reg", rrat_free_reg, 12);
`endif
        RESET = 1'b0;
        #1;
        chk("arst_free", rrat_free, 0);
        chk("arst_reg", rrat_free_reg, 0);
        chk("arst_halt", commit_halt, 0);
        chk("arst_map5", rrat_map[5], 5);
        chk("arst_retired", retired_num, 0);
        repeat (3) begin
            tick();
            chk("arst_hold_free", rrat_free, 0);
        end
        RESET = 1'b1;
        tick();
        tick();
        chk("post_rst_free", rrat_free, 0);
        chk("post_rst_halt", commit_halt, 0);
        chk("post_rst_map10", rrat_map[10], 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
